// File: rtl/polynomial_invert.sv
// Bisection solver for p(x) = target on [lo, hi] with a monotonic quintic p.
// p is evaluated by a sequential Horner loop, one saturating multiply-add per cycle.
module polynomial_invert #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int MAX_ITER   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 desc,
    input  logic signed [DATA_WIDTH-1:0]         target,
    input  logic signed [DATA_WIDTH-1:0]         lo_in,
    input  logic signed [DATA_WIDTH-1:0]         hi_in,
    input  logic signed [DATA_WIDTH-1:0]         a [0:5],
    output logic                                 busy,
    output logic                                 done,
    output logic                                 found,
    output logic                                 err,
    output logic signed [DATA_WIDTH-1:0]         x_out,
    output logic signed [DATA_WIDTH-1:0]         fx_out,
    output logic [$clog2(MAX_ITER+1)-1:0]        iter_count
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(MAX_ITER+1);
    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, MID, EVAL, CMP, DONE} state_t;

    state_t              state;
    logic signed [W-1:0] coef [0:5];
    logic signed [W-1:0] tgt, lo, hi, mid, acc, fx_lo;
    logic                desc_r;
    logic [2:0]          k;

    // Clamp a 2W-bit two's-complement value into W bits.
    function automatic logic signed [W-1:0] sat(input logic [2*W-1:0] v);
        if (v[2*W-1:W-1] == '0 || v[2*W-1:W-1] == '1)
            return v[W-1:0];
        else
            return v[2*W-1] ? SMIN : SMAX;
    endfunction

    // Midpoint in W+1 bits: hi >= lo always holds, so the result lies in [lo, hi].
    logic signed [W:0] diff_w, mid_w;
    assign diff_w = $signed({hi[W-1], hi}) - $signed({lo[W-1], lo});
    assign mid_w  = $signed({lo[W-1], lo}) + (diff_w >>> 1);

    logic [2*W-1:0]        prod_u, sum_u;
    logic signed [2*W-1:0] shifted;
    logic signed [W-1:0]   scaled, ak, horner;
    assign prod_u  = {{W{acc[W-1]}}, acc} * {{W{mid[W-1]}}, mid};
    assign shifted = $signed(prod_u) >>> FRAC_BITS;
    assign scaled  = sat(shifted);
    assign ak      = coef[k];
    assign sum_u   = {{W{scaled[W-1]}}, scaled} + {{W{ak[W-1]}}, ak};
    assign horner  = sat(sum_u);

    logic                hit, go_lo, close, at_max;
    logic signed [W-1:0] lo_n, hi_n;
    logic [W:0]          span;
    logic [CW-1:0]       it_n;
    assign hit    = (acc == tgt);
    assign go_lo  = (acc < tgt) ^ desc_r;
    assign lo_n   = go_lo ? mid : lo;
    assign hi_n   = go_lo ? hi : mid;
    assign span   = {hi_n[W-1], hi_n} - {lo_n[W-1], lo_n};
    assign close  = (span[W:1] == '0);
    assign it_n   = iter_count + 1'b1;
    assign at_max = (it_n == CW'(MAX_ITER));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            err        <= 1'b0;
            x_out      <= '0;
            fx_out     <= '0;
            iter_count <= '0;
            tgt        <= '0;
            lo         <= '0;
            hi         <= '0;
            mid        <= '0;
            acc        <= '0;
            fx_lo      <= '0;
            desc_r     <= 1'b0;
            k          <= '0;
            for (int i = 0; i < 6; i++) coef[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tgt        <= target;
                        lo         <= lo_in;
                        hi         <= hi_in;
                        desc_r     <= desc;
                        for (int i = 0; i < 6; i++) coef[i] <= a[i];
                        found      <= 1'b0;
                        err        <= 1'b0;
                        iter_count <= '0;
                        fx_lo      <= SMIN;
                        if (lo_in > hi_in) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            err    <= 1'b1;
                            x_out  <= lo_in;
                            fx_out <= '0;
                        end else begin
                            state <= MID;
                            busy  <= 1'b1;
                        end
                    end
                end
                MID: begin
                    mid   <= mid_w[W-1:0];
                    acc   <= coef[5];
                    k     <= 3'd4;
                    state <= EVAL;
                end
                EVAL: begin
                    acc <= horner;
                    if (k == 3'd0) state <= CMP;
                    else           k     <= k - 3'd1;
                end
                CMP: begin
                    iter_count <= it_n;
                    if (hit) begin
                        found  <= 1'b1;
                        x_out  <= mid;
                        fx_out <= acc;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        lo <= lo_n;
                        hi <= hi_n;
                        if (go_lo) fx_lo <= acc;
                        if (close || at_max) begin
                            x_out  <= lo_n;
                            fx_out <= go_lo ? acc : fx_lo;
                            found  <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= MID;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_polynomial_invert.sv
// Scoreboard bench for polynomial_invert: directed solves push expected results,
// monitors pop and compare on each done pulse (including the done cycle).
module tb_polynomial_invert;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start4 = 1'b0, desc = 1'b0;
    logic signed [15:0] target = '0, lo_in = '0, hi_in = '0;
    logic signed [15:0] a [0:5];

    logic busy, done, found, err;
    logic signed [15:0] x_out, fx_out;
    logic [4:0] iter_count;
    logic busy4, done4, found4, err4;
    logic signed [15:0] x_out4, fx_out4;
    logic [2:0] iter_count4;

    polynomial_invert #(.DATA_WIDTH(16), .FRAC_BITS(8), .MAX_ITER(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .desc(desc), .target(target),
        .lo_in(lo_in), .hi_in(hi_in), .a(a), .busy(busy), .done(done), .found(found),
        .err(err), .x_out(x_out), .fx_out(fx_out), .iter_count(iter_count));

    polynomial_invert #(.DATA_WIDTH(16), .FRAC_BITS(8), .MAX_ITER(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .desc(desc), .target(target),
        .lo_in(lo_in), .hi_in(hi_in), .a(a), .busy(busy4), .done(done4), .found(found4),
        .err(err4), .x_out(x_out4), .fx_out(fx_out4), .iter_count(iter_count4));

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int found; int err; int x; int fx; int it; int at;
    } exp_t;
    exp_t q[$];
    exp_t q4[$];
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("found", int'(found), e.found);
                chk("err", int'(err), e.err);
                chk("x_out", int'(x_out), e.x);
                chk("fx_out", int'(fx_out), e.fx);
                chk("iter_count", int'(iter_count), e.it);
                chk("done_cycle", int'(cyc), e.at);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done4) begin
            if (q4.size() == 0) begin
                chk("unexpected_done4", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("found4", int'(found4), e.found);
                chk("x_out4", int'(x_out4), e.x);
                chk("fx_out4", int'(fx_out4), e.fx);
                chk("iter_count4", int'(iter_count4), e.it);
                chk("done_cycle4", int'(cyc), e.at);
            end
        end
    end

    task automatic setup(input int c1, input int c2, input int tg, input int l, input int h,
                         input bit d);
        for (int i = 0; i < 6; i++) a[i] = '0;
        a[1] = 16'(c1);
        a[2] = 16'(c2);
        target = 16'(tg);
        lo_in = 16'(l);
        hi_in = 16'(h);
        desc = d;
    endtask

    // Pulse start for one cycle; lat is the expected done cycle counted from the accepting edge.
    task automatic issue(input bit to4, input bit push, input int f, input int e, input int x,
                         input int fx, input int it, input int lat);
        exp_t ex;
        @(negedge clk);
        ex.found = f; ex.err = e; ex.x = x; ex.fx = fx; ex.it = it;
        ex.at = int'(cyc) + lat;
        if (push) begin
            if (to4) q4.push_back(ex);
            else     q.push_back(ex);
        end
        if (to4) start4 = 1'b1;
        else     start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 400 && (q.size() != 0 || q4.size() != 0); i++) @(negedge clk);
        if (q.size() != 0 || q4.size() != 0) begin
            chk("timeout_pending", q.size() + q4.size(), 0);
            q.delete();
            q4.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_found"}, int'(found), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_x"}, int'(x_out), 0);
        chk({tag, "_fx"}, int'(fx_out), 0);
        chk({tag, "_iter"}, int'(iter_count), 0);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) a[i] = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // p = x, exact hit after 5 iterations; inputs scrambled after acceptance.
        setup(256, 0, 16'h0340, 0, 16'h0800, 1'b0);
        issue(0, 1, 1, 0, 16'h0340, 16'h0340, 5, 36);
        setup(0, 256, 16'h0100, 16'h0010, 16'h0020, 1'b1);
        drain();
        chk("hold_x_after_done", int'(x_out), 16'h0340);

        // p = x^2, no exact hit; bracket closes at 362/363.
        setup(0, 256, 16'h0200, 0, 16'h0200, 1'b0);
        issue(0, 1, 0, 0, 362, 511, 9, 64);
        drain();

        // Iteration cap of 4 on the second instance.
        setup(256, 0, 16'h0340, 0, 16'h0800, 1'b0);
        issue(1, 1, 0, 0, 768, 768, 4, 29);
        drain();

        // p = -x, decreasing.
        setup(-256, 0, -832, 0, 2048, 1'b1);
        issue(0, 1, 1, 0, 832, -832, 5, 36);
        drain();

        // lo > hi: immediate error, never busy.
        setup(256, 0, 16'h0340, 16'h0100, 0, 1'b0);
        issue(0, 1, 0, 1, 16'h0100, 0, 0, 1);
        chk("err_busy", int'(busy), 0);
        drain();

        // Second start during a solve is ignored.
        setup(256, 0, 16'h0340, 0, 16'h0800, 1'b0);
        issue(0, 1, 1, 0, 16'h0340, 16'h0340, 5, 36);
        repeat (7) @(negedge clk);
        target = 16'h0100;
        hi_in = 16'h0040;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset mid-solve: outputs clear at once and no done follows.
        setup(256, 0, 16'h0340, 0, 16'h0800, 1'b0);
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Normal solve after the abort.
        issue(0, 1, 1, 0, 16'h0340, 16'h0340, 5, 36);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/polynomial_invert.md
Name: polynomial_invert

Overview:
- Inverse companion to the pipelined polynomial evaluator: given a target y, finds x in [lo, hi] such that p(x) = y.
- p(x) = a0 + a1·x + … + a5·x^5, monotonic on the interval.
- Method: bisection, with a sequential Horner evaluator that performs one multiply-add per cycle.
- Used by the control path to invert calibration and transfer polynomials; fed by the same coefficient bank as the evaluator.

Parameters:
- DATA_WIDTH, 16: width of x, coefficients, target and fx (signed fixed point).
- FRAC_BITS, 8: fractional bits of the Q format used by all data and coefficients.
- MAX_ITER, 16: maximum bisection iterations per solve.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a solve; sampled only in IDLE.
- desc  in  1  1 = p is decreasing on [lo_in, hi_in]; 0 = increasing.
- target  in  DATA_WIDTH signed  y to invert.
- lo_in  in  DATA_WIDTH signed  lower x bound.
- hi_in  in  DATA_WIDTH signed  upper x bound.
- a  in  DATA_WIDTH signed ×6 (unpacked [0:5])  coefficients, a[k] multiplies x^k.
- busy  out  1  high in MID/EVAL/CMP.
- done  out  1  one-cycle pulse; results valid from this cycle.
- found  out  1  exact match p(x_out) = target.
- err  out  1  lo_in > hi_in at start.
- x_out  out  DATA_WIDTH signed  result x.
- fx_out  out  DATA_WIDTH signed  p(x_out) as computed.
- iter_count  out  $clog2(MAX_ITER+1)  iterations performed.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE.
  - busy, done, found, err = 0.
  - x_out, fx_out, iter_count = 0.
  - Reset mid-solve aborts immediately; no done pulse follows.
- Start acceptance:
  - start is accepted only in IDLE. On that edge, capture target, lo_in, hi_in, desc and a[0:5] into internal registers.
  - Clear found, err and iter_count.
  - Set fx_lo = −2^(DATA_WIDTH−1).
  - start in any other state is ignored. Input changes after acceptance have no effect.
- lo_in > hi_in on acceptance: next state is DONE with err = 1, found = 0, x_out = lo_in, fx_out = 0, iter_count = 0.
- MID state (1 cycle):
  - mid = lo + ((hi − lo) >>> 1), computed in DATA_WIDTH+1 bits; no overflow is possible.
  - acc = a[5], k = 4.
- EVAL state (5 cycles, k = 4..0):
  - Each cycle: acc = sat(sat((acc·mid) >>> FRAC_BITS) + a[k]).
  - Product is a full 2·DATA_WIDTH signed value with an arithmetic shift.
  - sat clamps to [−2^(W−1), 2^(W−1)−1].
- CMP state (1 cycle):
  - iter_count += 1; fx = acc.
  - If fx == target: found = 1, x_out = mid, fx_out = fx, go to DONE.
  - Else if (fx < target) XOR desc: lo = mid, fx_lo = fx.
  - Else: hi = mid.
  - Then, if (hi − lo) ≤ 1 or iter_count == MAX_ITER: x_out = lo, fx_out = fx_lo, found = 0, go to DONE. Otherwise go to MID.
- DONE state (1 cycle): done = 1, busy = 0, then IDLE. Outputs hold until the next accepted start.
- Timing: each iteration takes 7 cycles. For N iterations, done is high in cycle 7N+1, counting the cycle after the accepting edge as cycle 1. The err case has done in cycle 1.
- Minimum work: at least one iteration is always run, even when hi == lo.

Test Plan:
- p = x (a1 = 256, others 0), target = 0x0340, lo = 0, hi = 0x0800, desc = 0 -> mids 1024, 512, 768, 896, 832; found = 1, x_out = 0x0340, fx_out = 0x0340, iter_count = 5, done in cycle 36.
- p = x² (a2 = 256), target = 0x0200, lo = 0, hi = 0x0200 -> 9 iterations, no hit, terminates with lo = 362 / hi = 363; found = 0, x_out = 362, fx_out = 511, iter_count = 9, done in cycle 64.
- MAX_ITER = 4 instance, same stimulus as test 1 -> found = 0, x_out = 768, fx_out = 768, iter_count = 4, done in cycle 29.
- p = −x (a1 = −256), target = −832, lo = 0, hi = 2048, desc = 1 -> found = 1, x_out = 832, iter_count = 5.
- lo_in = 0x0100, hi_in = 0 -> done in cycle 1, err = 1, found = 0, iter_count = 0, busy never high.
- Start test 1, pulse start again in cycle 10 -> ignored, results identical to test 1. Separately, drop rst_n in cycle 20 -> all outputs 0 immediately, no done; a new start after reset solves normally.
